// File: rtl/spi_controller_if.sv
// spi_controller_if
//   Bundles the request/response handshake and the SPI pins of spi_controller.
//   master : requester side (drives the request fields) plus the target's MISO
//   slave  : the controller itself
//   Signals: ena, mode[1:0], req, wr_rdn, addr, wdata  -> controller
//            ready, done, rdata                        <- controller
//            spi_cs_n, spi_clk, spi_mosi               <- controller
//            spi_miso                                  -> controller
interface spi_controller_if #(
  parameter int REG_W = 8
);
  logic             ena;
  logic [1:0]       mode;
  logic             req;
  logic             wr_rdn;
  logic [REG_W-2:0] addr;
  logic [REG_W-1:0] wdata;
  logic             ready;
  logic             done;
  logic [REG_W-1:0] rdata;
  logic             spi_cs_n;
  logic             spi_clk;
  logic             spi_mosi;
  logic             spi_miso;

  modport master (
    output ena, mode, req, wr_rdn, addr, wdata, spi_miso,
    input  ready, done, rdata, spi_cs_n, spi_clk, spi_mosi
  );

  modport slave (
    input  ena, mode, req, wr_rdn, addr, wdata, spi_miso,
    output ready, done, rdata, spi_cs_n, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_controller.sv
// spi_controller
//   SPI initiator issuing single-register read/write frames of 2*REG_W bits,
//   MSB first: {wr_rdn, addr, data}. One request at a time; read data is
//   returned with a one-cycle done pulse.
//   Ports: clk   - system clock
//          rstb  - asynchronous active-low reset
//          bus   - spi_controller_if.slave (handshake + SPI pins)
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | CS high, spi_clk follows mode[1], waits for req && ready
//   S_SETUP | CS low, clock idle for CLK_DIV cycles
//   S_SHIFT | 4*REG_W half-periods of CLK_DIV cycles, clock toggling
//   S_HOLD  | CS low, clock idle for CLK_DIV cycles, then done
module spi_controller #(
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           rstb,
  spi_controller_if.slave bus
);

  localparam int FW    = 2 * REG_W;
  localparam int HP_N  = 4 * REG_W;
  localparam int HP_W  = $clog2(HP_N);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST = HP_W'(HP_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t           r_state, w_state;
  logic [DIV_W-1:0] r_div, w_div;
  logic [HP_W-1:0]  r_hp, w_hp;
  logic [FW-1:0]    r_shift, w_shift;
  logic [REG_W-1:0] r_rx, w_rx;
  logic [REG_W-1:0] r_rdata, w_rdata;
  logic             r_cs_n, w_cs_n;
  logic             r_sclk, w_sclk;
  logic             r_cpol, w_cpol;
  logic             r_cpha, w_cpha;
  logic             r_wr, w_wr;
  logic             r_done, w_done;
  logic             r_rdy, w_rdy;
  logic             w_lead;
  logic [REG_W-1:0] w_wdat;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_hp    <= '0;
      r_shift <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_hp    <= w_hp;
      r_shift <= w_shift;
      r_rx    <= w_rx;
      r_rdata <= w_rdata;
      r_cs_n  <= w_cs_n;
      r_sclk  <= w_sclk;
      r_cpol  <= w_cpol;
      r_cpha  <= w_cpha;
      r_wr    <= w_wr;
      r_done  <= w_done;
      r_rdy   <= w_rdy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_hp    = r_hp;
    w_shift = r_shift;
    w_rx    = r_rx;
    w_rdata = r_rdata;
    w_cs_n  = r_cs_n;
    w_sclk  = r_sclk;
    w_cpol  = r_cpol;
    w_cpha  = r_cpha;
    w_wr    = r_wr;
    w_done  = 1'b0;
    w_rdy   = 1'b0;
    // even half-period index ends on the leading edge
    w_lead  = ~r_hp[0];
    w_wdat  = bus.wr_rdn ? bus.wdata : '0;

    case (r_state)
      S_IDLE: begin
        w_cs_n = 1'b1;
        w_sclk = bus.mode[1];
        w_rdy  = 1'b1;
        if (bus.req && r_rdy && bus.ena) begin
          w_state = S_SETUP;
          w_cpol  = bus.mode[1];
          w_cpha  = bus.mode[0];
          w_wr    = bus.wr_rdn;
          w_shift = {bus.wr_rdn, bus.addr, w_wdat};
          w_rx    = '0;
          w_div   = DIV_MAX;
          w_hp    = '0;
          w_cs_n  = 1'b0;
          w_rdy   = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_div == '0) begin
          w_state = S_SHIFT;
          w_div   = DIV_MAX;
        end else begin
          w_div = r_div - 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_div == '0) begin
          w_div  = DIV_MAX;
          w_sclk = ~r_sclk;
          if (w_lead ^ r_cpha) begin
            w_rx = {r_rx[REG_W-2:0], bus.spi_miso};
          end else if (!(r_cpha && (r_hp == '0))) begin
            // CPHA=1 already presents the MSB, so the first leading edge holds it
            w_shift = {r_shift[FW-2:0], 1'b0};
          end
          if (r_hp == HP_LAST) begin
            w_state = S_HOLD;
          end else begin
            w_hp = r_hp + 1'b1;
          end
        end else begin
          w_div = r_div - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_div == '0) begin
          w_state = S_IDLE;
          w_cs_n  = 1'b1;
          w_done  = 1'b1;
          w_shift = '0;
          if (!r_wr) begin
            w_rdata = r_rx;
          end
        end else begin
          w_div = r_div - 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // disable aborts any frame without a done pulse
    if (!bus.ena) begin
      w_state = S_IDLE;
      w_cs_n  = 1'b1;
      w_sclk  = (r_state == S_IDLE) ? bus.mode[1] : r_cpol;
      w_done  = 1'b0;
      w_rdata = r_rdata;
      w_div   = '0;
      w_shift = '0;
      w_rdy   = 1'b1;
    end
  end

  assign bus.ready    = r_rdy & bus.ena;
  assign bus.done     = r_done;
  assign bus.rdata    = r_rdata;
  assign bus.spi_cs_n = r_cs_n;
  assign bus.spi_clk  = r_sclk;
  assign bus.spi_mosi = r_shift[FW-1];

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller
//   Directed bench for spi_controller with a behavioural register-bank target
//   on the SPI pins that honours all four SPI modes.
module tb_spi_controller;
  localparam int REG_W   = 8;
  localparam int CLK_DIV = 4;
  localparam int LAT     = 1 + (4 * REG_W + 2) * CLK_DIV;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_controller_if #(.REG_W(REG_W)) bus ();

  spi_controller #(.REG_W(REG_W), .CLK_DIV(CLK_DIV)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // target model state
  logic [7:0]  m_regs [0:127];
  logic [1:0]  m_mode = 2'b00;
  logic [15:0] m_last = 16'h0;
  int          m_frames = 0;
  logic        m_miso = 1'b0;

  assign bus.spi_miso = m_miso;

  initial begin : target
    logic [15:0] rx;
    logic [15:0] tx;
    logic        cpha;
    logic        lead;
    int          e;
    int          s;
    int          nb;
    for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
    m_regs[9] = 8'h3C;
    forever begin
      @(negedge bus.spi_cs_n);
      #1;
      cpha = m_mode[0];
      rx = 16'h0; tx = 16'h0; e = 0; s = 0;
      nb = cpha ? 15 : 14;
      m_miso = 1'b0;
      while (bus.spi_cs_n === 1'b0) begin
        @(bus.spi_clk or bus.spi_cs_n);
        #1;
        if (bus.spi_cs_n !== 1'b0) break;
        lead = ((e % 2) == 0);
        if (lead ^ cpha) begin
          rx = {rx[14:0], bus.spi_mosi};
          s++;
          if (s == 8 && !rx[7]) tx[7:0] = m_regs[rx[6:0]];
          if (s == 16) begin
            m_last = rx;
            m_frames++;
            if (rx[15]) m_regs[rx[14:8]] = rx[7:0];
          end
        end else if (nb >= 0) begin
          m_miso = tx[nb];
          nb--;
        end
        e++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and returns the number of cycles from the accept cycle
  // to the done cycle (-1 if done never came). Leaves the caller at the done negedge.
  task automatic do_frame(input logic wr, input logic [6:0] a, input logic [7:0] d,
                          input logic [1:0] md, output int lat);
    int w;
    lat = -1;
    @(negedge clk);
    m_mode = md;
    bus.mode = md; bus.wr_rdn = wr; bus.addr = a; bus.wdata = d; bus.req = 1'b1;
    w = 0;
    while (!bus.ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.req = 1'b0;
      return;
    end
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req = 1'b0;
        bus.addr = ~a; bus.wdata = ~d; bus.wr_rdn = ~wr;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int n_acc, n_done, gap, done_k, acc2_k, fr0, cnt;
    logic [7:0] dv;
    logic [1:0] md;

    bus.ena = 1'b1; bus.mode = 2'b00; bus.req = 1'b0;
    bus.wr_rdn = 1'b0; bus.addr = '0; bus.wdata = '0;
    #2 rstb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
    check("rst_sclk", 32'(bus.spi_clk), 32'd0);
    check("rst_mosi", 32'(bus.spi_mosi), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    rstb = 1'b1;

    // 1: mode0 write
    do_frame(1'b1, 7'h05, 8'hA5, 2'b00, lat);
    check("t1_lat", 32'(lat), 32'(LAT));
    check("t1_mosi", 32'(m_last), 32'h85A5);
    check("t1_rdata", 32'(bus.rdata), 32'h00);
    check("t1_cs_at_done", 32'(bus.spi_cs_n), 32'd1);
    check("t1_ready_at_done", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("t1_done_width", 32'(bus.done), 32'd0);
    check("t1_ready_after", 32'(bus.ready), 32'd1);

    // 2: mode0 read, target returns 0x3C
    do_frame(1'b0, 7'h09, 8'hFF, 2'b00, lat);
    check("t2_lat", 32'(lat), 32'(LAT));
    check("t2_mosi", 32'(m_last), 32'h0900);
    check("t2_rdata", 32'(bus.rdata), 32'h3C);

    // 3: write/read reg 2 in all four modes
    for (int m = 0; m < 4; m++) begin
      md = 2'(m);
      dv = 8'h5A + 8'(m);
      do_frame(1'b1, 7'h02, dv, md, lat);
      check("t3_wr_lat", 32'(lat), 32'(LAT));
      check("t3_wr_mosi", 32'(m_last), {16'h0, 8'h82, dv});
      check("t3_sclk_idle", 32'(bus.spi_clk), 32'(md[1]));
      do_frame(1'b0, 7'h02, 8'hFF, md, lat);
      check("t3_rd_mosi", 32'(m_last), 32'h0200);
      check("t3_rdata", 32'(bus.rdata), 32'(dv));
      @(negedge clk);
      check("t3_sclk_idle2", 32'(bus.spi_clk), 32'(md[1]));
    end

    // 4: req held high across two writes
    n_acc = 0; n_done = 0; gap = 0; done_k = -1; acc2_k = -1;
    fr0 = m_frames;
    @(negedge clk);
    m_mode = 2'b00;
    bus.mode = 2'b00; bus.wr_rdn = 1'b1; bus.addr = 7'h0A; bus.wdata = 8'h11; bus.req = 1'b1;
    for (int k = 0; k < 700; k++) begin
      if (n_acc == 1) begin
        bus.addr = 7'h0B; bus.wdata = 8'h22;
      end
      if (n_acc == 2 && k > acc2_k) bus.req = 1'b0;
      if (bus.req && bus.ready) begin
        n_acc++;
        if (n_acc == 2) acc2_k = k;
      end
      if (bus.done) begin
        n_done++;
        if (n_done == 1) done_k = k;
      end
      if (n_done == 1 && bus.spi_cs_n) gap++;
      if (n_done == 2) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("t4_accepts", 32'(n_acc), 32'd2);
    check("t4_dones", 32'(n_done), 32'd2);
    check("t4_cs_gap", 32'(gap), 32'd2);
    check("t4_reaccept", 32'(acc2_k - done_k), 32'd1);
    check("t4_frames", 32'(m_frames - fr0), 32'd2);
    check("t4_reg_a", 32'(m_regs[10]), 32'h11);
    check("t4_reg_b", 32'(m_regs[11]), 32'h22);
    check("t4_cs_idle", 32'(bus.spi_cs_n), 32'd1);

    // 5: ena low at half-period 10 of a read
    @(negedge clk);
    m_mode = 2'b10;
    bus.mode = 2'b10; bus.wr_rdn = 1'b0; bus.addr = 7'h09; bus.wdata = 8'h00; bus.req = 1'b1;
    cnt = 0;
    while (!bus.ready && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    repeat (46) begin
      @(negedge clk);
      bus.req = 1'b0;
    end
    check("t5_in_frame", 32'(bus.spi_cs_n), 32'd0);
    bus.ena = 1'b0;
    @(negedge clk);
    check("t5_cs_abort", 32'(bus.spi_cs_n), 32'd1);
    check("t5_sclk_abort", 32'(bus.spi_clk), 32'd1);
    check("t5_ready_off", 32'(bus.ready), 32'd0);
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("t5_no_done", 32'(cnt), 32'd0);
    check("t5_rdata_kept", 32'(bus.rdata), 32'h5D);
    bus.ena = 1'b1;
    do_frame(1'b0, 7'h09, 8'h00, 2'b00, lat);
    check("t5_next_lat", 32'(lat), 32'(LAT));
    check("t5_next_rdata", 32'(bus.rdata), 32'h3C);

    // 6: reset pulse mid-frame
    @(negedge clk);
    m_mode = 2'b10;
    bus.mode = 2'b10; bus.wr_rdn = 1'b1; bus.addr = 7'h03; bus.wdata = 8'h44; bus.req = 1'b1;
    cnt = 0;
    while (!bus.ready && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    repeat (60) begin
      @(negedge clk);
      bus.req = 1'b0;
    end
    rstb = 1'b0;
    #1;
    check("t6_cs_n", 32'(bus.spi_cs_n), 32'd1);
    check("t6_sclk", 32'(bus.spi_clk), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    check("t6_rdata", 32'(bus.rdata), 32'd0);
    check("t6_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    check("t6_no_partial", 32'(m_regs[3]), 32'h00);
    do_frame(1'b1, 7'h03, 8'h77, 2'b00, lat);
    check("t6_lat", 32'(lat), 32'(LAT));
    check("t6_mosi", 32'(m_last), 32'h8377);
    check("t6_reg", 32'(m_regs[3]), 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
